// File: rtl/univ_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : univ_mod_counter
// Description : Up/down counter with a programmable step over the range
//               [0, lim]. Each step wraps modulo lim+1 or saturates, and a
//               registered terminal-count pulse marks boundary crossings.
//               Define UNIV_CNT_STICKY_OVF_EN to build the sticky ovf flag.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syn_clr,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lim,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic              max,
    output logic              min,
    output logic              tc,
    output logic              ovf
);

    localparam int c_XW = WIDTH + 1;

    logic [WIDTH-1:0] r_q;
    logic             r_tc;

    logic [c_XW-1:0]  w_q_x;
    logic [c_XW-1:0]  w_lim_x;
    logic [c_XW-1:0]  w_lim_p1;
    logic [c_XW-1:0]  w_step_x;
    logic [c_XW-1:0]  w_s;
    logic [c_XW-1:0]  w_sum;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_count;
    logic [WIDTH-1:0] w_load_val;

    // Extended operands: q+s and q+lim+1 both fit in WIDTH+1 bits.
    assign w_q_x    = {1'b0, r_q};
    assign w_lim_x  = {1'b0, lim};
    assign w_lim_p1 = w_lim_x + c_XW'(1);
    assign w_step_x = {{(c_XW-STEP_W){1'b0}}, step};
    assign w_s      = (w_step_x > w_lim_p1) ? w_lim_p1 : w_step_x;
    assign w_sum    = w_q_x + w_s;

    assign w_count    = en && (step != '0);
    assign w_load_val = (d > lim) ? lim : d;

    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (w_q_x > w_lim_x) begin
            // lim was lowered below q: snap to the bound in the count direction
            w_q_nxt  = up ? '0 : lim;
            w_tc_nxt = 1'b1;
        end else if (up) begin
            if (w_sum <= w_lim_x) begin
                w_q_nxt = WIDTH'(w_sum);
            end else begin
                w_tc_nxt = 1'b1;
                w_q_nxt  = sat ? lim : WIDTH'(w_sum - w_lim_p1);
            end
        end else begin
            if (w_q_x >= w_s) begin
                w_q_nxt = WIDTH'(w_q_x - w_s);
            end else begin
                w_tc_nxt = 1'b1;
                w_q_nxt  = sat ? '0 : WIDTH'(w_q_x + w_lim_p1 - w_s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else if (syn_clr) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else if (load) begin
            r_q  <= w_load_val;
            r_tc <= 1'b0;
        end else if (w_count) begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
        end else begin
            r_tc <= 1'b0;
        end
    end

`ifdef UNIV_CNT_STICKY_OVF_EN
    logic r_ovf;

    // syn_clr together with load is the explicit flag-clear command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (syn_clr && load) begin
            r_ovf <= 1'b0;
        end else if (!syn_clr && !load && w_count && w_tc_nxt) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign q   = r_q;
    assign tc  = r_tc;
    assign max = (r_q == lim);
    assign min = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_univ_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_mod_counter
// Description : Directed self-checking bench for univ_mod_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_mod_counter;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
`ifdef UNIV_CNT_STICKY_OVF_EN
    localparam logic c_STICKY = 1'b1;
`else
    localparam logic c_STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, syn_clr, load, en, up, sat;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lim, d, q;
    logic              max, min, tc, ovf;

    int n_pass = 0;
    int n_total = 0;

    univ_mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
        .up(up), .sat(sat), .step(step), .lim(lim), .d(d),
        .q(q), .max(max), .min(min), .tc(tc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_q_tc(input string tag, input int eq, input logic etc);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".tc"}, 32'(tc), 32'(etc));
    endtask

    initial begin
        // Reset wins over every other control
        reset = 1; syn_clr = 1; load = 1; en = 1; up = 1; sat = 0;
        step = 1; lim = 9; d = 1;
        tick();
        chk_q_tc("reset", 0, 0);
        check("reset.ovf", 32'(ovf), 0);
        check("reset.min", 32'(min), 1);
        check("reset.max", 32'(max), 0);
        lim = 0; #1;
        check("reset.max_lim0", 32'(max), 1);
        lim = 9;

        // Wrap count 0..9 -> 0
        reset = 0; syn_clr = 0; load = 0; en = 1; up = 1; sat = 0; step = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("wrap9.q", 32'(q), 32'(i % 10));
            check("wrap9.tc", 32'(tc), 32'(i == 10));
            check("wrap9.max", 32'(max), 32'(i == 9));
        end
        check("wrap9.ovf", 32'(ovf), 32'(c_STICKY));

        // 20 non-wrapping counts keep ovf
        lim = 200;
        for (int i = 1; i <= 20; i++) tick();
        chk_q_tc("count20", 20, 0);
        check("count20.ovf", 32'(ovf), 32'(c_STICKY));

        syn_clr = 1; tick(); syn_clr = 0;
        chk_q_tc("synclr", 0, 0);
        check("synclr.ovf", 32'(ovf), 32'(c_STICKY));

        syn_clr = 1; load = 1; d = 50; tick(); syn_clr = 0; load = 0;
        chk_q_tc("flagclr", 0, 0);
        check("flagclr.ovf", 32'(ovf), 0);

        // Step 3 wrap up then down
        lim = 9; d = 8; load = 1; tick(); load = 0;
        chk_q_tc("ld8", 8, 0);
        step = 3; up = 1; tick();
        chk_q_tc("up3wrap", 1, 1);
        up = 0; tick();
        chk_q_tc("dn3wrap", 8, 1);
        tick();
        chk_q_tc("dn3", 5, 0);

        // Saturation
        lim = 200; sat = 1; d = 2; load = 1; tick(); load = 0;
        up = 0; step = 4; tick();
        chk_q_tc("satdn", 0, 1);
        tick();
        chk_q_tc("satdn_again", 0, 1);
        d = 198; load = 1; tick(); load = 0;
        up = 1; tick();
        chk_q_tc("satup", 200, 1);
        check("satup.max", 32'(max), 1);
        tick();
        chk_q_tc("satup_again", 200, 1);

        // Load clamp, flag clear, step 0, lowered lim
        lim = 150; d = 200; load = 1; tick(); load = 0;
        chk_q_tc("ldclamp", 150, 0);
        syn_clr = 1; load = 1; d = 50; tick(); syn_clr = 0; load = 0;
        chk_q_tc("clrld", 0, 0);
        d = 150; load = 1; tick(); load = 0;
        step = 0; en = 1; tick();
        chk_q_tc("step0", 150, 0);
        lim = 20; step = 1; up = 1; tick();
        chk_q_tc("guard_up", 0, 1);
        lim = 150; d = 100; load = 1; tick(); load = 0;
        lim = 20; up = 0; tick();
        chk_q_tc("guard_dn", 20, 1);

        // Step larger than range is clamped to lim+1
        sat = 0; lim = 2; d = 1; load = 1; tick(); load = 0;
        step = 15; up = 1; tick();
        chk_q_tc("stepclamp", 1, 1);

        // lim == 0 pins q
        lim = 0; d = 5; load = 1; tick(); load = 0;
        chk_q_tc("lim0ld", 0, 0);
        step = 1; tick();
        chk_q_tc("lim0cnt", 0, 1);
        check("lim0.max", 32'(max), 1);
        check("lim0.min", 32'(min), 1);

        // en=0 holds
        lim = 9; d = 4; load = 1; tick(); load = 0;
        en = 0; tick();
        chk_q_tc("hold", 4, 0);

        // Mid-count reset, then first action on the next edge
        check("pre_reset.ovf", 32'(ovf), 32'(c_STICKY));
        en = 1; up = 1; step = 1; reset = 1; tick();
        chk_q_tc("midreset", 0, 0);
        check("midreset.ovf", 32'(ovf), 0);
        reset = 0; tick();
        chk_q_tc("postreset", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/univ_mod_counter.md
# univ_mod_counter

Parametrised universal counter. It counts up or down by a programmable step inside a runtime range [0, lim]. Each step either wraps modulo lim+1 or saturates at the bounds. It keeps the synchronous-clear, load and enable controls of the universal binary counter and adds a registered terminal-count pulse. It is the general-purpose counter for timers, address generators and divider chains in the design.

## Interface
Parameters:
- WIDTH, 8, counter/data width in bits (>= 2)
- STEP_W, 4, width of the step input (STEP_W <= WIDTH)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- syn_clr  in  1  synchronous clear of q
- load  in  1  load d into q
- en  in  1  count enable
- up  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at bounds, 0 = wrap modulo lim+1
- step  in  STEP_W  increment magnitude
- lim  in  WIDTH  upper bound of the count range (inclusive)
- d  in  WIDTH  load value
- q  out  WIDTH  count value (registered)
- max  out  1  q == lim (combinational from q and lim)
- min  out  1  q == 0 (combinational from q)
- tc  out  1  terminal-count pulse (registered)
- ovf  out  1  sticky boundary flag (registered; see Configuration)

## Operation
- Control priority, highest first: reset > syn_clr > load > en. At most one action is taken per edge.
- reset: q=0, tc=0, ovf=0.
- syn_clr: q=0, tc=0. ovf is unchanged.
- load: q = min(d, lim), tc=0.
- en with step==0: q holds and tc=0.
- Otherwise en=0: q holds and tc=0.
- Enabled count:
  - Arithmetic is done in WIDTH+1 bits.
  - Effective step s = min(step, lim+1).
  - Out-of-range guard: if q > lim (lim was lowered), next q = 0 when up=1 and lim when up=0, with tc=1. This applies in both modes.
  - Up, q+s <= lim: next q = q+s, tc=0.
  - Up, q+s > lim: wrap mode gives q+s-(lim+1); sat mode gives lim. tc=1 in both modes.
  - Down, q >= s: next q = q-s, tc=0.
  - Down, q < s: wrap mode gives q-s+(lim+1); sat mode gives 0. tc=1 in both modes.
- tc therefore fires on every enabled step that crosses a bound, including repeated clipped steps while saturated at a bound.
- lim == 0: q is pinned to 0. max=min=1. Every enabled step with step != 0 gives tc=1.
- up, sat, step, lim and d are sampled on the same edge as the controls. There is no internal registering of the mode inputs.

## Timing
- Single clock domain. Latency from control to q is one edge.
- tc is high for exactly the one cycle in which q shows the post-boundary value. It is low otherwise.
- max and min follow q in the same cycle as q. They also respond combinationally to a change of lim.
- Reset mid-count takes effect on the next edge regardless of the other inputs.
- After reset deasserts, the first action is taken on the following edge.
- Back-to-back enabled cycles count on every edge. No bubble is inserted.

## Configuration
- UNIV_CNT_STICKY_OVF_EN defined:
  - ovf is set on any edge where tc is set.
  - It stays set until reset, or until an edge with syn_clr=1 and load=1 together (explicit flag clear; q is also cleared by syn_clr).
  - Plain syn_clr does not clear ovf.
- UNIV_CNT_STICKY_OVF_EN undefined: ovf is tied to 0 and the flag register is not built. All other behaviour is identical.

## Test plan
- Reset with syn_clr=load=en=up=1 and d=1 -> q=0, tc=0, ovf=0 after one edge. min=1. max=1 only if lim=0.
- lim=9, step=1, up=1, sat=0, en=1 from q=0 -> q counts 1..9 then 0. max=1 at q=9. tc=1 exactly in the cycle q returns to 0, once per 10 cycles.
- lim=9, step=3, up=1, sat=0, q=8 -> q=1, tc=1. Then with up=0, step=3: q=8, tc=1. Then q=5, tc=0.
- lim=200, sat=1, up=0, step=4, q=2 -> q=0, tc=1. Next enabled edge -> q=0, tc=1. With up=1 and q=198 -> q=200, tc=1, max=1.
- lim=150: load with d=200 -> q=150. syn_clr=1 with load=1, d=50 -> q=0. step=0 with en=1 -> q holds, tc=0. Lower lim to 20 with q=150, up=1, en=1 -> q=0, tc=1.
- With UNIV_CNT_STICKY_OVF_EN defined: one wrap sets ovf. ovf stays 1 through 20 non-wrapping counts and a plain syn_clr. It clears on syn_clr+load, and on reset. Without the macro, ovf=0 throughout the same stimulus.
